// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler state encoding
// and data/frame sizing constants.
// No ports; imported by the scheduler, its interface and its bench.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_FRAME  = 2'd2,
        S_GAP    = 2'd3
    } sched_state_t;

    localparam int UART_DATA_W           = 8;
    localparam int UART_FRAME_CYCLES_DEF = 13;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle between N_REQ byte producers, the scheduler and the frame transmitter.
// master: producer side (drives req_valid/req_data, observes everything else).
// slave: scheduler side (accepts bytes, drives transmitter controls and status).
import uart_pkg::*;

interface uart_tx_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]             req_valid;
    logic [UART_DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;
    logic                         tx_idle_bit;
    logic                         tx_start_bit;
    logic [UART_DATA_W-1:0]       tx_data;
    logic                         busy;
    logic [IDX_W-1:0]             grant_id;
    logic                         frame_done;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_idle_bit, tx_start_bit, tx_data, busy, grant_id, frame_done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_idle_bit, tx_start_bit, tx_data, busy, grant_id, frame_done
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; gnt is all-zero when no request is set.
// Ports: req (N requests), ptr (search start), gnt (one-hot), gnt_idx (binary).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int W = $clog2(N);

    logic [W-1:0] idx;
    logic         found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            // Candidate k positions above ptr, folded back into 0..N-1.
            idx = W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one serial frame transmitter among N_REQ byte producers.
// Latency: accept at T, launch at T+1, frame_done at T+1+FRAME_CYCLES, next accept T+2+FRAME_CYCLES+GAP_CYCLES.
// Backpressure: req_ready pulses only in S_IDLE; producers hold valid/data until they see it.
// Ports: clk, rst (async, active-high), bus (slave modport: requests in, transmitter controls/status out).
import uart_pkg::*;

module uart_tx_scheduler #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = UART_FRAME_CYCLES_DEF,
    parameter int GAP_CYCLES   = 2
) (
    input logic                clk,
    input logic                rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int             IDX_W      = $clog2(N_REQ);
    localparam logic [7:0]     FRAME_LOAD = 8'(FRAME_CYCLES - 1);
    localparam logic [7:0]     GAP_LOAD   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    sched_state_t           state, state_nxt;
    logic [7:0]             cnt, cnt_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_q;
    logic [UART_DATA_W-1:0] data_q;
    logic                   busy_q;

    logic [N_REQ-1:0]       arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic [UART_DATA_W-1:0] sel_byte;
    logic                   accept;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Gating with rst keeps req_ready at its reset value while reset is held,
    // so no producer believes a byte was taken that the FFs never captured.
    assign accept = (state == S_IDLE) && (|bus.req_valid) && !rst;

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_byte = bus.req_data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_nxt   = FRAME_LOAD;
                state_nxt = S_FRAME;
            end
            S_FRAME: begin
                if (cnt == 8'd0) begin
                    cnt_nxt   = GAP_LOAD;
                    state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            grant_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            // Registered copy of "not idle next cycle", i.e. state != S_IDLE.
            busy_q <= (state_nxt != S_IDLE);
            if (accept) begin
                data_q  <= sel_byte;
                grant_q <= arb_idx;
                rr_ptr  <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    assign bus.req_ready    = accept ? arb_gnt : '0;
    assign bus.tx_idle_bit  = (state != S_LAUNCH);
    assign bus.tx_start_bit = (state != S_LAUNCH);
    assign bus.tx_data      = data_q;
    assign bus.busy         = busy_q;
    assign bus.grant_id     = grant_q;
    assign bus.frame_done   = (state == S_FRAME) && (cnt == 8'd0);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: one instance with defaults (N_REQ=4, 13, 2) and
// one with GAP_CYCLES=0 fed by a single always-valid requester.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
import uart_pkg::*;

module tb_uart_tx_scheduler;

    localparam int N     = 4;
    localparam int FRAME = 13;
    localparam int GAP   = 2;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.N_REQ(N)) a_if ();
    uart_tx_scheduler_if #(.N_REQ(N)) b_if ();

    uart_tx_scheduler #(.N_REQ(N), .FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    uart_tx_scheduler #(.N_REQ(N), .FRAME_CYCLES(FRAME), .GAP_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard of expected launches on dut_a: pushed when a request is driven.
    typedef struct {
        int         id;
        logic [7:0] dat;
    } exp_t;
    exp_t sb[$];

    int         a_launch_n = 0;
    int         a_done_n   = 0;
    int         a_exp_done = -1;
    int         a_last_acc = -100;
    logic [7:0] a_cur_dat  = 8'h00;
    exp_t       a_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (|(a_if.req_valid & a_if.req_ready)) begin
                chk("a_ready_onehot", 64'($onehot(a_if.req_ready)), 64'd1);
                a_last_acc = cyc;
            end
            if (!a_if.tx_idle_bit) begin
                a_launch_n++;
                chk("a_launch_start_bit", 64'(a_if.tx_start_bit), 64'd0);
                chk("a_launch_latency", 64'(cyc), 64'(a_last_acc + 1));
                if (sb.size() == 0) begin
                    fail("a_unexpected_launch");
                end else begin
                    a_e = sb.pop_front();
                    chk("a_grant_id", 64'(a_if.grant_id), 64'(a_e.id));
                    chk("a_tx_data", 64'(a_if.tx_data), 64'(a_e.dat));
                    a_cur_dat = a_e.dat;
                end
                a_exp_done = cyc + FRAME;
            end
            if (a_if.frame_done) begin
                a_done_n++;
                chk("a_done_time", 64'(cyc), 64'(a_exp_done));
                chk("a_done_data", 64'(a_if.tx_data), 64'(a_cur_dat));
            end
        end
    end

    // dut_b: one requester always valid, no gap -> accept every FRAME+2 cycles.
    int b_acc_n    = 0;
    int b_launch_n = 0;
    int b_last_acc = -100;

    always @(negedge clk) begin
        if (!rst_b) begin
            if (|(b_if.req_valid & b_if.req_ready)) begin
                if (b_acc_n > 0) chk("b_spacing", 64'(cyc - b_last_acc), 64'(FRAME + 2));
                b_last_acc = cyc;
                b_acc_n++;
            end
            if (!b_if.tx_idle_bit) begin
                b_launch_n++;
                chk("b_launch_latency", 64'(cyc), 64'(b_last_acc + 1));
                chk("b_tx_data", 64'(b_if.tx_data), 64'hC3);
                chk("b_grant_id", 64'(b_if.grant_id), 64'd1);
            end
        end
    end

    task automatic wait_acc_a(input int lim, output int idx, output int at, output logic [N-1:0] rdy);
        idx = -1;
        at  = -1;
        rdy = '0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (|(a_if.req_valid & a_if.req_ready)) begin
                rdy = a_if.req_ready;
                at  = cyc;
                for (int j = 0; j < N; j++) if (rdy[j]) idx = j;
                return;
            end
        end
        fail("a_accept_timeout");
    endtask

    typedef struct {
        logic [N-1:0]  valid;
        logic [31:0]   data;
        logic [N-1:0]  exp_rdy;
        int            exp_id;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int           idx, at, t0, prev, r;
        logic [N-1:0] rdy;
        logic [31:0]  d;

        // Starting from rr_ptr=3 (left by the single-request test).
        tbl[0] = '{4'b0010, 32'h03020100, 4'b0010, 1};
        tbl[1] = '{4'b1111, 32'h13121110, 4'b0100, 2};
        tbl[2] = '{4'b1001, 32'h23222120, 4'b1000, 3};
        tbl[3] = '{4'b1001, 32'h33323130, 4'b0001, 0};
        tbl[4] = '{4'b0001, 32'h43424140, 4'b0001, 0};
        tbl[5] = '{4'b1000, 32'h53525150, 4'b1000, 3};
        tbl[6] = '{4'b0110, 32'h63626160, 4'b0010, 1};
        tbl[7] = '{4'b0101, 32'h73727170, 4'b0100, 2};

        a_if.req_valid = '0;
        a_if.req_data  = '0;
        b_if.req_valid = '0;
        b_if.req_data  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(a_if.req_ready), 64'd0);
        chk("rst_idle_bit", 64'(a_if.tx_idle_bit), 64'd1);
        chk("rst_start_bit", 64'(a_if.tx_start_bit), 64'd1);
        chk("rst_tx_data", 64'(a_if.tx_data), 64'd0);
        chk("rst_busy", 64'(a_if.busy), 64'd0);
        chk("rst_grant_id", 64'(a_if.grant_id), 64'd0);
        chk("rst_frame_done", 64'(a_if.frame_done), 64'd0);
        a_if.req_valid = 4'hF;
        #1;
        chk("rst_ready_held_low", 64'(a_if.req_ready), 64'd0);
        a_if.req_valid = '0;

        tick();
        rst   = 1'b0;
        rst_b = 1'b0;
        b_if.req_data  = 32'h0000C300;
        b_if.req_valid = 4'b0010;

        // No requests: line stays idle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_line", 64'(a_if.tx_idle_bit), 64'd1);
            chk("idle_busy", 64'(a_if.busy), 64'd0);
        end

        // Round robin with all four continuously valid.
        tick();
        a_if.req_data  = 32'h44332211;
        a_if.req_valid = 4'hF;
        sb.push_back('{0, 8'h11});
        sb.push_back('{1, 8'h22});
        sb.push_back('{2, 8'h33});
        sb.push_back('{3, 8'h44});
        sb.push_back('{0, 8'h11});
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            wait_acc_a(40, idx, at, rdy);
            chk("rr_grant", 64'(idx), 64'(k % N));
            if (k > 0) chk("rr_spacing", 64'(at - prev), 64'(FRAME + GAP + 2));
            prev = at;
        end
        tick();
        a_if.req_valid = '0;

        // Single request, frame timing, then immediate re-request of the same producer.
        a_if.req_data  = 32'h00A50000;
        a_if.req_valid = 4'b0100;
        sb.push_back('{2, 8'hA5});
        sb.push_back('{2, 8'h5A});
        wait_acc_a(40, idx, t0, rdy);
        chk("single_grant", 64'(idx), 64'd2);
        chk("single_ready", 64'(rdy), 64'b0100);
        tick();
        a_if.req_data = 32'h005A0000;
        for (int dd = 1; dd <= 16; dd++) begin
            @(negedge clk);
            chk("single_idle_bit", 64'(a_if.tx_idle_bit), (dd == 1) ? 64'd0 : 64'd1);
            chk("single_tx_data", 64'(a_if.tx_data), 64'hA5);
            chk("single_busy", 64'(a_if.busy), 64'd1);
            chk("single_frame_done", 64'(a_if.frame_done), (dd == 14) ? 64'd1 : 64'd0);
            chk("single_ready_blocked", 64'(a_if.req_ready), 64'd0);
        end
        wait_acc_a(5, idx, at, rdy);
        chk("single_next_accept", 64'(at - t0), 64'(FRAME + GAP + 2));
        chk("single_regrant", 64'(idx), 64'd2);
        tick();
        a_if.req_valid = '0;

        // Table: arbitration from a known pointer across request patterns.
        for (int k = 0; k < 8; k++) begin
            tick();
            d = tbl[k].data;
            sb.push_back('{tbl[k].exp_id, d[8*tbl[k].exp_id +: 8]});
            a_if.req_data  = d;
            a_if.req_valid = tbl[k].valid;
            wait_acc_a(40, idx, at, rdy);
            chk("tbl_grant", 64'(idx), 64'(tbl[k].exp_id));
            chk("tbl_ready", 64'(rdy), 64'(tbl[k].exp_rdy));
            tick();
            a_if.req_valid = '0;
        end

        // Reset in the middle of a frame (cnt=5), with another request pending.
        tick();
        a_if.req_data  = 32'h00000077;
        a_if.req_valid = 4'b0001;
        sb.push_back('{0, 8'h77});
        wait_acc_a(40, idx, t0, rdy);
        chk("mid_grant", 64'(idx), 64'd0);
        tick();
        a_if.req_valid = '0;
        repeat (8) tick();
        rst = 1'b1;
        a_if.req_data  = 32'h99000000;
        a_if.req_valid = 4'b1000;
        sb.push_back('{3, 8'h99});
        #1;
        chk("mid_rst_tx_data", 64'(a_if.tx_data), 64'd0);
        chk("mid_rst_busy", 64'(a_if.busy), 64'd0);
        chk("mid_rst_idle_bit", 64'(a_if.tx_idle_bit), 64'd1);
        chk("mid_rst_frame_done", 64'(a_if.frame_done), 64'd0);
        chk("mid_rst_grant_id", 64'(a_if.grant_id), 64'd0);
        chk("mid_rst_ready", 64'(a_if.req_ready), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        r   = cyc;
        wait_acc_a(3, idx, at, rdy);
        chk("post_rst_accept_cycle", 64'(at), 64'(r));
        chk("post_rst_grant", 64'(idx), 64'd3);
        tick();
        a_if.req_valid = '0;
        repeat (30) tick();

        chk("a_frames_done", 64'(a_done_n), 64'd16);
        chk("a_launches", 64'(a_launch_n), 64'd17);
        chk("a_scoreboard_empty", 64'(sb.size()), 64'd0);

        b_if.req_valid = '0;
        repeat (20) tick();
        chk("b_enough_accepts", 64'(b_acc_n >= 5), 64'd1);
        chk("b_one_launch_per_frame", 64'(b_launch_n), 64'(b_acc_n));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
